// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over a raster-ordered valid/ready stream.
// Even rows fold horizontal pairs into a half-row buffer; odd rows combine
// their own pair with the buffered value and emit one pooled sample per block.
module maxpool2x2_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int ROW_WIDTH  = 26,
    parameter int ROWS       = 26
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o,
    output logic                  busy_o
);

    localparam int CW    = $clog2(ROW_WIDTH);
    localparam int RW    = $clog2(ROWS);
    localparam int DEPTH = ROW_WIDTH / 2;
    localparam int KW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] pair_q;
    logic [DATA_WIDTH-1:0] row_buf [DEPTH];

    logic                  accept;
    logic                  xfer;
    logic                  col_last;
    logic                  row_last;
    logic                  load_out;
    logic                  write_buf;
    logic [KW-1:0]         k;
    logic [DATA_WIDTH-1:0] pair_max;
    logic [DATA_WIDTH-1:0] blk_max;

    assign in_ready_o = !clear_i && (!out_valid_o || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign xfer       = out_valid_o && out_ready_i;
    assign col_last   = (col == CW'(ROW_WIDTH - 1));
    assign row_last   = (row == RW'(ROWS - 1));
    assign k          = KW'(col >> 1);
    assign write_buf  = accept && !row[0] && col[0];
    assign load_out   = accept && row[0] && col[0];

    // Signed maxima: horizontal pair, then pair against the buffered upper row
    always_comb begin
        pair_max = pair_q;
        if ($signed(in_data_i) > $signed(pair_q)) begin
            pair_max = in_data_i;
        end
        blk_max = row_buf[k];
        if ($signed(pair_max) > $signed(row_buf[k])) begin
            blk_max = pair_max;
        end
    end

    // Half-row buffer: always written on an even row before being read on the odd row
    always_ff @(posedge clk_i) begin
        if (write_buf) begin
            row_buf[k] <= pair_max;
        end
    end

    // Position counters, pair register, output register and frame status
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col         <= '0;
            row         <= '0;
            pair_q      <= '0;
            out_data_o  <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else if (clear_i) begin
            col         <= '0;
            row         <= '0;
            pair_q      <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            if (accept) begin
                if (!col[0]) begin
                    pair_q <= in_data_i;
                end
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            // A load in the same cycle as a transfer keeps valid high back-to-back
            if (load_out) begin
                out_data_o  <= blk_max;
                out_valid_o <= 1'b1;
                out_last_o  <= row_last && col_last;
            end else if (xfer) begin
                out_valid_o <= 1'b0;
            end

            // Accept of the next frame's first sample wins over the last transfer
            if (accept) begin
                busy_o <= 1'b1;
            end else if (xfer && out_last_o) begin
                busy_o <= 1'b0;
            end
        end
    end

endmodule
